brushless_ctrl: RTL and testbench

Commutation and drive sequencer for the three-phase e-bike motor driver. Synchronizes the three hall sensors to the PWM period, selects the per-phase drive mode (`selGrn`/`selYlw`/`selBlu`) from the rotor position, and produces a slew-limited `duty` for the PWM stage. It also handles regenerative braking and a latched fault on illegal hall codes. It sits between the torque/assist computation (`drv_mag`, `brake`) and `mtr_drv`, and consumes `PWM_synch` from it.

---
 rtl/mtr_ctrl_pkg.sv | 47 ++++
 rtl/hall_sync.sv | 39 +++
 rtl/brushless_ctrl.sv | 149 ++++++++++++++
 tb/tb_brushless_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mtr_ctrl_pkg.sv
// Shared types, constants and commutation lookup for the
// brushless motor drive sequencer.
package mtr_ctrl_pkg;

    typedef enum logic [1:0] {
        HIGH_Z    = 2'b00,
        REV_CURR  = 2'b01,
        FWD_CURR  = 2'b10,
        REGEN_BRK = 2'b11
    } sel_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BRAKE,
        FAULT
    } state_t;

    typedef struct packed {
        sel_t grn;
        sel_t ylw;
        sel_t blu;
    } sel3_t;

    localparam logic [10:0] DUTY_NEUTRAL = 11'h400;
    localparam logic [10:0] DUTY_BRAKE   = 11'h600;

    function automatic logic hall_legal(input logic [2:0] hall);
        return (hall != 3'b000) && (hall != 3'b111);
    endfunction

    function automatic sel3_t commutate(input logic [2:0] hall);
        sel3_t s;
        s = '{HIGH_Z, HIGH_Z, HIGH_Z};
        case (hall)
            3'b101:  s = '{FWD_CURR, REV_CURR, HIGH_Z};
            3'b100:  s = '{FWD_CURR, HIGH_Z, REV_CURR};
            3'b110:  s = '{HIGH_Z, FWD_CURR, REV_CURR};
            3'b010:  s = '{REV_CURR, FWD_CURR, HIGH_Z};
            3'b011:  s = '{REV_CURR, HIGH_Z, FWD_CURR};
            3'b001:  s = '{HIGH_Z, REV_CURR, FWD_CURR};
            default: s = '{HIGH_Z, HIGH_Z, HIGH_Z};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hall_sync.sv
// Double-flop synchronizers for the hall sensors plus a sample
// register that only loads at the PWM-safe sampling point.
module hall_sync
    import mtr_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hallGrn,
    input  logic       hallYlw,
    input  logic       hallBlu,
    input  logic       PWM_synch,
    output logic [2:0] hall_smp
);

    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;
    logic [2:0] smp_q, smp_d;

    always_comb begin
        meta_d = {hallGrn, hallYlw, hallBlu};
        sync_d = meta_q;
        smp_d  = PWM_synch ? sync_q : smp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 3'b000;
            sync_q <= 3'b000;
            smp_q  <= 3'b000;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            smp_q  <= smp_d;
        end
    end

    assign hall_smp = smp_q;

endmodule

// File: rtl/brushless_ctrl.sv
// Commutation/drive sequencer: state machine, illegal-hall fault
// counter and slew-limited duty, all advanced once per PWM period.
module brushless_ctrl
    import mtr_ctrl_pkg::*;
#(
    parameter int unsigned RAMP_STEP     = 8,
    parameter int unsigned FAULT_PERIODS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic        PWM_synch,
    input  logic [11:0] drv_mag,
    input  logic        brake,
    input  logic        clr_fault,
    output logic [10:0] duty,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic        fault
);

    localparam logic [10:0] STEP11 = 11'(RAMP_STEP);
    localparam logic [11:0] STEP12 = 12'(RAMP_STEP);
    localparam logic [2:0]  FLIM   = 3'(FAULT_PERIODS);

    logic [2:0]  hall_smp;
    logic        tick_q, tick_d;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [10:0] duty_q, duty_d;
    sel3_t       sel_q, sel_d;

    logic               legal;
    logic               drv_nz;
    logic [10:0]        target;
    sel3_t              sel_nxt;
    logic signed [11:0] diff;
    logic signed [11:0] step_s;

    hall_sync u_hall_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .hallGrn   (hallGrn),
        .hallYlw   (hallYlw),
        .hallBlu   (hallBlu),
        .PWM_synch (PWM_synch),
        .hall_smp  (hall_smp)
    );

    // Everything advances one clock after the sample edge,
    // so hall_smp is already the fresh value here.
    always_comb begin
        tick_d  = PWM_synch;
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        sel_d   = sel_q;
        legal   = hall_legal(hall_smp);
        drv_nz  = |drv_mag;
        target  = DUTY_NEUTRAL;
        sel_nxt = '{HIGH_Z, HIGH_Z, HIGH_Z};
        step_s  = $signed(STEP12);
        diff    = 12'sd0;

        if (tick_q) begin
            if (legal) begin
                cnt_d = 3'd0;
            end else if (cnt_q != 3'd7) begin
                cnt_d = cnt_q + 3'd1;
            end

            if (state_q != FAULT && cnt_d >= FLIM) begin
                state_d = FAULT;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (brake)       state_d = BRAKE;
                        else if (drv_nz) state_d = RUN;
                    end
                    RUN: begin
                        if (brake)        state_d = BRAKE;
                        else if (!drv_nz) state_d = IDLE;
                    end
                    BRAKE: begin
                        if (!brake) state_d = IDLE;
                    end
                    FAULT: begin
                        if (clr_fault && legal) state_d = IDLE;
                    end
                endcase
            end

            unique case (state_d)
                IDLE: begin
                    target = DUTY_NEUTRAL;
                end
                RUN: begin
                    target  = DUTY_NEUTRAL + {1'b0, drv_mag[11:2]};
                    sel_nxt = commutate(hall_smp);
                end
                BRAKE: begin
                    target  = DUTY_BRAKE;
                    sel_nxt = '{REGEN_BRK, REGEN_BRK, REGEN_BRK};
                end
                FAULT: begin
                    target = DUTY_NEUTRAL;
                end
            endcase
            sel_d = sel_nxt;

            diff = $signed({1'b0, target}) - $signed({1'b0, duty_q});
            if (state_d == FAULT) begin
                duty_d = DUTY_NEUTRAL;
            end else if (diff > step_s) begin
                duty_d = duty_q + STEP11;
            end else if (diff < -step_s) begin
                duty_d = duty_q - STEP11;
            end else begin
                duty_d = target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            duty_q  <= DUTY_NEUTRAL;
            sel_q   <= '{HIGH_Z, HIGH_Z, HIGH_Z};
        end else begin
            tick_q  <= tick_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            sel_q   <= sel_d;
        end
    end

    assign duty   = duty_q;
    assign selGrn = sel_q.grn;
    assign selYlw = sel_q.ylw;
    assign selBlu = sel_q.blu;
    assign fault  = (state_q == FAULT);

endmodule

// File: tb/tb_brushless_ctrl.sv
// Directed vector bench for brushless_ctrl: commutation, ramping,
// braking, hall fault handling, sample timing and async reset.
module tb_brushless_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hallGrn = 1'b0;
    logic        hallYlw = 1'b0;
    logic        hallBlu = 1'b0;
    logic        PWM_synch = 1'b0;
    logic [11:0] drv_mag = 12'h000;
    logic        brake = 1'b0;
    logic        clr_fault = 1'b0;
    logic [10:0] duty;
    logic [1:0]  selGrn, selYlw, selBlu;
    logic        fault;

    int total = 0;
    int bad = 0;

    brushless_ctrl #(.RAMP_STEP(8), .FAULT_PERIODS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hallGrn   (hallGrn),
        .hallYlw   (hallYlw),
        .hallBlu   (hallBlu),
        .PWM_synch (PWM_synch),
        .drv_mag   (drv_mag),
        .brake     (brake),
        .clr_fault (clr_fault),
        .duty      (duty),
        .selGrn    (selGrn),
        .selYlw    (selYlw),
        .selBlu    (selBlu),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  hall;
        logic [11:0] drv;
        logic        brk;
        logic        clr;
        logic [10:0] duty;
        logic [5:0]  sel;
        logic        flt;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];
    vec_t tab_c[$];

    function automatic vec_t mk(input logic [2:0] h, input logic [11:0] d,
                                input logic b, input logic c,
                                input logic [10:0] du, input logic [5:0] s,
                                input logic f);
        vec_t v;
        v.hall = h; v.drv = d; v.brk = b; v.clr = c;
        v.duty = du; v.sel = s; v.flt = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] h, input logic [11:0] d,
                          input logic b, input logic c);
        {hallGrn, hallYlw, hallBlu} = h;
        drv_mag = d;
        brake = b;
        clr_fault = c;
    endtask

    // Settle the synchronizers, pulse PWM_synch, return after N+1.
    task automatic period();
        repeat (3) @(negedge clk);
        PWM_synch = 1'b1;
        @(negedge clk);
        PWM_synch = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v, input string nm);
        set_in(v.hall, v.drv, v.brk, v.clr);
        period();
        chk({nm, ".duty"}, 32'(duty), 32'(v.duty));
        chk({nm, ".sel"}, 32'({selGrn, selYlw, selBlu}), 32'(v.sel));
        chk({nm, ".fault"}, 32'(fault), 32'(v.flt));
    endtask

    initial begin
        logic [10:0] e;
        int guard;

        tab_a.push_back(mk(3'b101, 12'h800, 0, 0, 11'h408, 6'b10_01_00, 0));
        tab_a.push_back(mk(3'b100, 12'h800, 0, 0, 11'h410, 6'b10_00_01, 0));
        tab_a.push_back(mk(3'b110, 12'h800, 0, 0, 11'h418, 6'b00_10_01, 0));
        tab_a.push_back(mk(3'b010, 12'h800, 0, 0, 11'h420, 6'b01_10_00, 0));
        tab_a.push_back(mk(3'b011, 12'h800, 0, 0, 11'h428, 6'b01_00_10, 0));
        tab_a.push_back(mk(3'b001, 12'h800, 0, 0, 11'h430, 6'b00_01_10, 0));

        tab_b.push_back(mk(3'b101, 12'h800, 1, 0, 11'h600, 6'b11_11_11, 0));
        tab_b.push_back(mk(3'b101, 12'h000, 0, 0, 11'h5F8, 6'b00_00_00, 0));

        tab_c.push_back(mk(3'b101, 12'h100, 0, 0, 11'h408, 6'b10_01_00, 0));
        tab_c.push_back(mk(3'b111, 12'h100, 0, 0, 11'h410, 6'b00_00_00, 0));
        tab_c.push_back(mk(3'b111, 12'h100, 0, 0, 11'h418, 6'b00_00_00, 0));
        tab_c.push_back(mk(3'b101, 12'h100, 0, 0, 11'h420, 6'b10_01_00, 0));
        tab_c.push_back(mk(3'b000, 12'h100, 0, 0, 11'h428, 6'b00_00_00, 0));
        tab_c.push_back(mk(3'b000, 12'h100, 0, 0, 11'h430, 6'b00_00_00, 0));
        tab_c.push_back(mk(3'b000, 12'h100, 0, 0, 11'h400, 6'b00_00_00, 1));
        tab_c.push_back(mk(3'b000, 12'h100, 0, 1, 11'h400, 6'b00_00_00, 1));
        tab_c.push_back(mk(3'b101, 12'h100, 0, 0, 11'h400, 6'b00_00_00, 1));
        tab_c.push_back(mk(3'b110, 12'h100, 0, 1, 11'h400, 6'b00_00_00, 0));
        tab_c.push_back(mk(3'b110, 12'h100, 0, 0, 11'h408, 6'b00_10_01, 0));

        repeat (2) @(negedge clk);
        chk("rst.duty", 32'(duty), 32'h400);
        chk("rst.sel", 32'({selGrn, selYlw, selBlu}), 32'h0);
        chk("rst.fault", 32'(fault), 32'h0);
        rst_n = 1'b1;

        foreach (tab_a[i]) apply(tab_a[i], $sformatf("sweep%0d", i));
        for (int i = 1; i <= 58; i++) begin
            set_in(3'b101, 12'h800, 0, 0);
            period();
            chk($sformatf("ramp_up%0d", i), 32'(duty), 32'h430 + 32'(8 * i));
        end
        chk("ramp_up.sel", 32'({selGrn, selYlw, selBlu}), 32'b10_01_00);

        foreach (tab_b[i]) apply(tab_b[i], $sformatf("brake%0d", i));
        for (int k = 1; k <= 63; k++) begin
            set_in(3'b101, 12'h000, 0, 0);
            period();
            chk($sformatf("ramp_dn%0d", k), 32'(duty), 32'h5F8 - 32'(8 * k));
        end

        foreach (tab_c[i]) apply(tab_c[i], $sformatf("flt%0d", i));

        e = 11'h408;
        guard = 0;
        while (e != 11'h7FF && guard < 200) begin
            e = (11'h7FF - e <= 11'd8) ? 11'h7FF : e + 11'd8;
            set_in(3'b110, 12'hFFF, 0, 0);
            period();
            chk("max_ramp", 32'(duty), 32'(e));
            guard++;
        end
        chk("max_ramp.steps", 32'(guard), 32'd127);
        period();
        chk("max_hold", 32'(duty), 32'h7FF);

        set_in(3'b011, 12'hFFF, 0, 0);
        repeat (6) @(negedge clk);
        chk("nosynch.sel", 32'({selGrn, selYlw, selBlu}), 32'b00_10_01);
        PWM_synch = 1'b1;
        @(negedge clk);
        PWM_synch = 1'b0;
        chk("edgeN.sel", 32'({selGrn, selYlw, selBlu}), 32'b00_10_01);
        @(negedge clk);
        chk("edgeN1.sel", 32'({selGrn, selYlw, selBlu}), 32'b01_00_10);
        chk("edgeN1.duty", 32'(duty), 32'h7FF);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2.duty", 32'(duty), 32'h400);
        rst_n = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            set_in(3'b101, 12'h800, 0, 0);
            period();
        end
        chk("mid.duty", 32'(duty), 32'h520);
        chk("mid.sel", 32'({selGrn, selYlw, selBlu}), 32'b10_01_00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async.duty", 32'(duty), 32'h400);
        chk("async.sel", 32'({selGrn, selYlw, selBlu}), 32'h0);
        chk("async.fault", 32'(fault), 32'h0);
        #10 rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
